seq_check_sink: RTL

- Terminal consumer that reads a socket from its output side and checks the received stream against the incrementing counter sequence produced by the counter source.
- Sits after the last socket of a chain, in place of a plain void sink.
- Pulls words in frames of SOCKET_SIZE, optionally idles between frames to apply backpressure, and reports word, frame and error statistics.

---
 rtl/seq_check_sink.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seq_check_sink.sv
// Terminal socket consumer: pulls frames of SOCKET_SIZE words and checks them
// against an incrementing counter sequence, reporting word/frame/error stats.
module seq_check_sink #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned SOCKET_SIZE  = 5,
   parameter int unsigned INIT_VALUE   = 0,
   parameter int unsigned STALL_CYCLES = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_enable,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_dv,
   input  logic                  i_empty,
   output logic                  o_rd_en,
   output logic                  o_frame_done,
   output logic                  o_mismatch,
   output logic                  o_err,
   output logic                  o_proto_err,
   output logic [31:0]           o_word_count,
   output logic [15:0]           o_frame_count,
   output logic [15:0]           o_err_count,
   output logic                  o_busy
);

   localparam int unsigned CNT_W = $clog2(SOCKET_SIZE + 1);
   localparam int unsigned ST_W  = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_STALL = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_issued;
   logic [CNT_W-1:0]      r_received;
   logic [CNT_W-1:0]      w_recv_nxt;
   logic [ST_W-1:0]       r_stall_cnt;
   logic [DATA_WIDTH-1:0] r_expected;
   logic                  r_rd_pend;
   logic                  w_dv_ok;
   logic                  w_dv_bad;
   logic                  w_word_bad;
   logic                  w_last_req;
   logic                  w_frame_end;
   logic                  w_stall_end;

   assign o_rd_en    = (r_state == S_READ) && !i_empty && (r_issued < CNT_W'(SOCKET_SIZE));
   assign w_last_req = o_rd_en && (r_issued == CNT_W'(SOCKET_SIZE - 1));
   assign w_dv_ok    = i_dv && r_rd_pend;
   assign w_dv_bad   = i_dv && !r_rd_pend;
   assign w_word_bad = w_dv_ok && (i_data != r_expected);
   // Completion counts the word arriving this cycle so DRAIN can end on it.
   assign w_recv_nxt = r_received + CNT_W'(w_dv_ok);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_frame_end = 1'b0;
      w_stall_end = 1'b0;
      case (r_state)
         S_IDLE:  if (i_enable) w_state_nxt = S_READ;
         S_READ:  if (w_last_req) w_state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (w_recv_nxt == CNT_W'(SOCKET_SIZE)) begin
               w_frame_end = 1'b1;
               if (STALL_CYCLES > 0) w_state_nxt = S_STALL;
               else if (i_enable)    w_state_nxt = S_READ;
               else                  w_state_nxt = S_IDLE;
            end
         end
         S_STALL: begin
            if (r_stall_cnt == ST_W'(STALL_CYCLES - 1)) begin
               w_stall_end = 1'b1;
               w_state_nxt = i_enable ? S_READ : S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Frame bookkeeping, sequence checking and statistics.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_issued      <= '0;
         r_received    <= '0;
         r_stall_cnt   <= '0;
         r_expected    <= DATA_WIDTH'(INIT_VALUE);
         r_rd_pend     <= 1'b0;
         o_frame_done  <= 1'b0;
         o_mismatch    <= 1'b0;
         o_err         <= 1'b0;
         o_proto_err   <= 1'b0;
         o_word_count  <= '0;
         o_frame_count <= '0;
         o_err_count   <= '0;
         o_busy        <= 1'b0;
      end else begin
         r_rd_pend    <= o_rd_en;
         o_busy       <= (w_state_nxt != S_IDLE);
         o_frame_done <= w_frame_end;
         o_mismatch   <= w_word_bad;

         if (w_frame_end) begin
            r_issued      <= '0;
            r_received    <= '0;
            o_frame_count <= o_frame_count + 16'd1;
         end else begin
            if (o_rd_en) r_issued <= r_issued + CNT_W'(1);
            r_received <= w_recv_nxt;
         end

         if (r_state == S_STALL) begin
            if (w_stall_end) r_stall_cnt <= '0;
            else             r_stall_cnt <= r_stall_cnt + ST_W'(1);
         end

         if (w_dv_ok) begin
            o_word_count <= o_word_count + 32'd1;
            if (w_word_bad) begin
               // Resync on the received word so one bad word costs one error.
               r_expected <= i_data + DATA_WIDTH'(1);
               o_err      <= 1'b1;
               if (o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
            end else begin
               r_expected <= r_expected + DATA_WIDTH'(1);
            end
         end

         if (w_dv_bad) begin
            o_proto_err <= 1'b1;
            o_err       <= 1'b1;
         end
      end
   end

endmodule
